// File: rtl/fsm4_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fsm4_seq_arbiter
// Description : Round-robin sharing of one 2-bit "11"-pair history detector;
//               serialises each granted frame MSB-first, counts S3 cycles,
//               flushes the detector and returns the count with a done pulse.
//               Optional shadow check enabled by FSM4_SEQ_SHADOW_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm4_seq_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FRAME_W = 8,
  localparam int ID_W  = $clog2(NUM_REQ),
  localparam int CNT_W = $clog2(FRAME_W)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*FRAME_W-1:0] frame_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       det_in,
  input  logic [1:0]                 det_state,
  output logic                       busy,
  output logic                       done,
  output logic [ID_W-1:0]            done_id,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       chk_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [FRAME_W-1:0] r_shift;
  logic [NUM_REQ-1:0] r_grant;
  logic [ID_W-1:0]    r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_flush_cnt;
  logic               r_done;
  logic [ID_W-1:0]    r_done_id;
  logic [CNT_W-1:0]   r_match_cnt;

  logic               w_any;
  logic [ID_W-1:0]    w_sel_idx;
  logic [FRAME_W-1:0] w_sel_frame;
  logic               w_s3;

  // Search starts one past the last owner so every requester gets its turn.
  always_comb begin
    int v_idx;
    w_any       = 1'b0;
    w_sel_idx   = '0;
    w_sel_frame = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      v_idx = int'(r_ptr) + i;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (!w_any && req[v_idx]) begin
        w_any       = 1'b1;
        w_sel_idx   = ID_W'(v_idx);
        w_sel_frame = frame_data[v_idx*FRAME_W +: FRAME_W];
      end
    end
  end

  assign w_s3 = (det_state == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_grant     <= '0;
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_flush_cnt <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= '0;
      r_match_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_shift     <= w_sel_frame;
            r_grant     <= NUM_REQ'(1) << w_sel_idx;
            r_ptr       <= w_sel_idx;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          r_shift <= r_shift << 1;
          // Bit 0 has no predecessor, so S3 cannot appear on the first cycle.
          if (r_bit_cnt != '0 && w_s3) r_cnt <= r_cnt + CNT_W'(1);
          if (r_bit_cnt == CNT_W'(FRAME_W - 1)) begin
            r_flush_cnt <= 1'b0;
            r_state     <= FLUSH;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        FLUSH: begin
          // First flush cycle still shows the pair formed by the last two bits.
          if (!r_flush_cnt && w_s3) r_cnt <= r_cnt + CNT_W'(1);
          r_flush_cnt <= 1'b1;
          if (r_flush_cnt) begin
            r_done      <= 1'b1;
            r_done_id   <= r_ptr;
            r_match_cnt <= r_cnt;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_grant <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign det_in    = (r_state == SHIFT) ? r_shift[FRAME_W-1] : 1'b0;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign done_id   = r_done_id;
  assign match_cnt = r_match_cnt;

`ifdef FSM4_SEQ_SHADOW_CHK_EN
  logic [1:0] r_shadow;
  logic       r_chk_err;
  logic       w_chk_en;

  assign w_chk_en = ((r_state == SHIFT) && (r_bit_cnt != '0)) ||
                    (r_state == FLUSH) || (r_state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= 2'b00;
      r_chk_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any)
        r_shadow <= 2'b00;
      else if (r_state == SHIFT || r_state == FLUSH)
        r_shadow <= {r_shadow[0], det_in};
      if (w_chk_en && (det_state != r_shadow))
        r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm4_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm4_seq_arbiter
// Description : Directed self-checking bench with a behavioural detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm4_seq_arbiter;

  localparam int NUM_REQ = 4;
  localparam int FRAME_W = 8;
`ifdef FSM4_SEQ_SHADOW_CHK_EN
  localparam logic EXP_CHK = 1'b1;
`else
  localparam logic EXP_CHK = 1'b0;
`endif

  logic                       clk;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*FRAME_W-1:0] frame_data;
  logic [NUM_REQ-1:0]         grant;
  logic                       det_in;
  logic [1:0]                 det_state;
  logic                       busy;
  logic                       done;
  logic [1:0]                 done_id;
  logic [2:0]                 match_cnt;
  logic                       chk_err;

  logic [1:0] det_model;
  logic       force_s3;
  int         n_vec;
  int         n_err;

  fsm4_seq_arbiter #(.NUM_REQ(NUM_REQ), .FRAME_W(FRAME_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .frame_data (frame_data),
    .grant      (grant),
    .det_in     (det_in),
    .det_state  (det_state),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .match_cnt  (match_cnt),
    .chk_err    (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector: state = {previous bit, last bit}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) det_model <= 2'b00;
    else        det_model <= {det_model[0], det_in};
  end
  assign det_state = force_s3 ? 2'b11 : det_model;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int exp_id, input int exp_cnt);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < 40);
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_done_id"}, 32'(done_id), 32'(exp_id));
    chk({tag, "_match_cnt"}, 32'(match_cnt), 32'(exp_cnt));
    chk({tag, "_grant"}, 32'(grant), 32'(1 << exp_id));
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    req        = '0;
    frame_data = '0;
    force_s3   = 1'b0;
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_det_in", 32'(det_in), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_done_id", 32'(done_id), 32'h0);
    chk("rst_match_cnt", 32'(match_cnt), 32'h0);
    chk("rst_chk_err", 32'(chk_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: single frame 0xFF on req[0]
    req = 4'b0001;
    frame_data[0 +: 8] = 8'hFF;
    tick();
    req = 4'b0000;
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_det_in", 32'(det_in), 32'h1);
    wait_done("t1", 10, 0, 7);
    tick();
    chk("t1_grant_drop", 32'(grant), 32'h0);
    chk("t1_done_pulse", 32'(done), 32'h0);
    chk("t1_idle_det_state", 32'(det_state), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_idle_det_in", 32'(det_in), 32'h0);
    chk("t1_cnt_hold", 32'(match_cnt), 32'h7);

    // 2: 0xA5 then 0xE7 on req[2]; frame changed after arbitration
    req = 4'b0100;
    frame_data[16 +: 8] = 8'hA5;
    tick();
    req = 4'b0000;
    frame_data[16 +: 8] = 8'hFF;
    wait_done("t2a", 10, 2, 0);
    tick();
    req = 4'b0100;
    frame_data[16 +: 8] = 8'hE7;
    tick();
    req = 4'b0000;
    wait_done("t2b", 10, 2, 4);
    tick();

    // 5: req[3] dropped on SHIFT cycle 2
    req = 4'b1000;
    frame_data[24 +: 8] = 8'hF0;
    tick();
    tick();
    tick();
    req = 4'b0000;
    wait_done("t5", 8, 3, 3);
    tick();

    // 3: all requesting, pointer at 3 so order is 0,1,2,3,0
    frame_data = {8'h7F, 8'hDB, 8'h81, 8'h3C};
    req = 4'b1111;
    wait_done("t3_r0", 11, 0, 3);
    wait_done("t3_r1", 12, 1, 0);
    wait_done("t3_r2", 12, 2, 3);
    wait_done("t3_r3", 12, 3, 6);
    wait_done("t3_r0b", 12, 0, 3);
    req = 4'b0000;
    tick();

    // 4: reset during SHIFT cycle 4 of a req[1] frame
    req = 4'b0010;
    frame_data[8 +: 8] = 8'hFF;
    tick();
    repeat (4) tick();
    chk("t4_pre_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_grant", 32'(grant), 32'h0);
    chk("t4_rst_busy", 32'(busy), 32'h0);
    chk("t4_rst_det_in", 32'(det_in), 32'h0);
    chk("t4_rst_done", 32'(done), 32'h0);
    chk("t4_rst_match_cnt", 32'(match_cnt), 32'h0);
    chk("t4_rst_done_id", 32'(done_id), 32'h0);
    req = 4'b0011;
    frame_data[0 +: 8] = 8'h0F;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    req = 4'b0000;
    chk("t4_first_grant", 32'(grant), 32'h1);
    wait_done("t4", 10, 0, 3);
    tick();

    // 6: corrupt detector state during FLUSH cycle 1
    req = 4'b0001;
    frame_data[0 +: 8] = 8'hA5;
    tick();
    req = 4'b0000;
    repeat (9) tick();
    force_s3 = 1'b1;
    tick();
    force_s3 = 1'b0;
    chk("t6_done", 32'(done), 32'h1);
    chk("t6_match_cnt", 32'(match_cnt), 32'h0);
    chk("t6_chk_err", 32'(chk_err), 32'(EXP_CHK));
    repeat (3) tick();
    chk("t6_chk_err_sticky", 32'(chk_err), 32'(EXP_CHK));
    rst_n = 1'b0;
    #1;
    chk("t6_chk_err_rst", 32'(chk_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
